// File: rtl/l1_dcache_pkg.sv
// Shared types, FSM encodings and helpers for the L1 data cache.
package l1_dcache_pkg;

  localparam int unsigned C_NUM_LINES   = 8;
  localparam int unsigned C_OFFSET_BITS = 4;
  localparam int unsigned C_INDEX_BITS  = 3;
  localparam int unsigned C_TAG_BITS    = 16 - C_OFFSET_BITS - C_INDEX_BITS;
  localparam int unsigned C_LINE_BITS   = 8 << C_OFFSET_BITS;

  typedef logic [C_TAG_BITS-1:0]    lc3b_c_tag;
  typedef logic [C_INDEX_BITS-1:0]  lc3b_c_index;
  typedef logic [C_OFFSET_BITS-1:0] lc3b_c_offset;
  typedef logic [C_LINE_BITS-1:0]   lc3b_c_line;

  // Cache controller state encoding.
  typedef logic [1:0] cache_state_t;
  localparam cache_state_t S_IDLE      = 2'd0;
  localparam cache_state_t S_WRITEBACK = 2'd1;
  localparam cache_state_t S_ALLOCATE  = 2'd2;

  // Byte-lane merge of a 16-bit store into an existing word.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic [1:0]  be);
    logic [15:0] res;
    res = old_word;
    if (be[0]) res[7:0]  = new_word[7:0];
    if (be[1]) res[15:8] = new_word[15:8];
    return res;
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Generic per-line storage array with a combinational read port and a
// single write port. Only the valid/dirty instances use the async reset.
module l1_dcache_array
  import l1_dcache_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned DEPTH     = C_NUM_LINES,
  parameter bit          HAS_RESET = 1'b0,
  localparam int unsigned IDX_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end

  assign rdata = mem_q[idx];

  if (HAS_RESET) begin : g_rst
    // Status bits are cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '{default: '0};
      else        mem_q <= mem_d;
    end
  end else begin : g_norst
    // Payload storage has no reset; writes are simply blocked while reset is low.
    always_ff @(posedge clk) begin
      if (rst_n) mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
//
// state       | meaning
// S_IDLE      | serve hits combinationally; on a miss pick writeback or fill
// S_WRITEBACK | victim line is dirty, push it to physical memory
// S_ALLOCATE  | fetch the requested line from physical memory
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES   = C_NUM_LINES,
  parameter int unsigned OFFSET_BITS = C_OFFSET_BITS,
  localparam int unsigned IDX_BITS   = $clog2(NUM_LINES),
  localparam int unsigned TAG_BITS   = 16 - OFFSET_BITS - IDX_BITS,
  localparam int unsigned LINE_BITS  = 8 << OFFSET_BITS,
  localparam int unsigned WSEL_BITS  = OFFSET_BITS - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           mem_byte_enable,
  input  logic [15:0]          mem_addr,
  input  logic [15:0]          mem_wdata,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [15:0]          pmem_addr,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  cache_state_t state_q, state_d;

  logic [TAG_BITS-1:0]  req_tag;
  logic [IDX_BITS-1:0]  req_idx;
  logic [WSEL_BITS-1:0] req_word;
  logic                 unused_addr_lsb;

  logic [LINE_BITS-1:0] data_rd, data_wdata, line_merged;
  logic [TAG_BITS-1:0]  tag_rd;
  logic                 valid_rd, dirty_rd;
  logic                 data_we, tag_we, valid_we, dirty_we;
  logic                 valid_wdata, dirty_wdata;
  logic                 hit;
  logic [15:0]          sel_word;

  assign req_tag         = mem_addr[15 -: TAG_BITS];
  assign req_idx         = mem_addr[OFFSET_BITS +: IDX_BITS];
  assign req_word        = mem_addr[OFFSET_BITS-1:1];
  assign unused_addr_lsb = mem_addr[0];

  assign hit      = valid_rd && (tag_rd == req_tag);
  assign sel_word = data_rd[{req_word, 4'b0000} +: 16];

  // Store data merged into the resident line at the addressed word.
  always_comb begin
    line_merged = data_rd;
    line_merged[{req_word, 4'b0000} +: 16] = merge_bytes(sel_word, mem_wdata, mem_byte_enable);
  end

  // Controller: next state, handshake outputs and array write strobes.
  always_comb begin
    state_d     = state_q;
    mem_resp    = 1'b0;
    mem_rdata   = '0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = '0;
    pmem_wdata  = '0;
    data_we     = 1'b0;
    data_wdata  = line_merged;
    tag_we      = 1'b0;
    valid_we    = 1'b0;
    valid_wdata = 1'b0;
    dirty_we    = 1'b0;
    dirty_wdata = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp = 1'b1;
            // A write takes priority over a simultaneous read.
            if (mem_write) begin
              if (mem_byte_enable != 2'b00) begin
                data_we     = 1'b1;
                dirty_we    = 1'b1;
                dirty_wdata = 1'b1;
              end
            end else begin
              mem_rdata = sel_word;
            end
          end else if (valid_rd && dirty_rd) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_rd, req_idx, {OFFSET_BITS{1'b0}}};
        pmem_wdata = data_rd;
        if (pmem_resp) begin
          dirty_we = 1'b1;
          state_d  = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          data_we     = 1'b1;
          data_wdata  = pmem_rdata;
          tag_we      = 1'b1;
          valid_we    = 1'b1;
          valid_wdata = 1'b1;
          dirty_we    = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight physical memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  l1_dcache_array #(.WIDTH(LINE_BITS), .DEPTH(NUM_LINES), .HAS_RESET(1'b0)) u_data (
    .clk(clk), .rst_n(rst_n), .we(data_we), .idx(req_idx), .wdata(data_wdata), .rdata(data_rd)
  );

  l1_dcache_array #(.WIDTH(TAG_BITS), .DEPTH(NUM_LINES), .HAS_RESET(1'b0)) u_tag (
    .clk(clk), .rst_n(rst_n), .we(tag_we), .idx(req_idx), .wdata(req_tag), .rdata(tag_rd)
  );

  l1_dcache_array #(.WIDTH(1), .DEPTH(NUM_LINES), .HAS_RESET(1'b1)) u_valid (
    .clk(clk), .rst_n(rst_n), .we(valid_we), .idx(req_idx), .wdata(valid_wdata), .rdata(valid_rd)
  );

  l1_dcache_array #(.WIDTH(1), .DEPTH(NUM_LINES), .HAS_RESET(1'b1)) u_dirty (
    .clk(clk), .rst_n(rst_n), .we(dirty_we), .idx(req_idx), .wdata(dirty_wdata), .rdata(dirty_rd)
  );

endmodule

// File: tb/tb_l1_dcache.sv
// Directed testbench for l1_dcache.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_addr;
  logic [127:0] pmem_wdata, pmem_rdata;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [127:0] LINE_A     = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                         16'h3333, 16'h2222, 16'h3456, 16'hBEEF};
  localparam logic [127:0] LINE_A_MOD = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                         16'hCD33, 16'h2222, 16'h34AB, 16'hBEEF};
  localparam logic [127:0] LINE_B     = {112'h0, 16'hA0A0};
  localparam logic [127:0] LINE_B_MOD = {96'h0, 16'h5A5A, 16'hA0A0};

  l1_dcache dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and stop at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_byte_enable = be; mem_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_addr, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Cold read miss of 0x1000
    set_req(1'b1, 1'b0, 16'h1000, 2'b00, 16'h0); #1;
    check("miss_no_resp", mem_resp, 0);
    tick(); #1;
    check("fill_pmem_read", pmem_read, 1);
    check("fill_pmem_write", pmem_write, 0);
    check("fill_pmem_addr", pmem_addr, 16'h1000);
    check("fill_no_resp", mem_resp, 0);
    tick();
    pmem_rdata = LINE_A; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; #1;
    check("fill_done_resp", mem_resp, 1);
    check("fill_done_rdata", mem_rdata, 16'hBEEF);
    check("fill_done_pmem_read", pmem_read, 0);
    tick(); #1;

    // Repeat hit, then another word of the same line
    check("hit_resp", mem_resp, 1);
    check("hit_rdata", mem_rdata, 16'hBEEF);
    check("hit_pmem_read", pmem_read, 0);
    mem_addr = 16'h100E; #1;
    check("hit_word7", mem_rdata, 16'h7777);
    tick();

    // Byte writes and readback
    set_req(1'b0, 1'b1, 16'h1002, 2'b01, 16'h12AB); #1;
    check("wr_lo_resp", mem_resp, 1);
    tick();
    set_req(1'b1, 1'b0, 16'h1002, 2'b00, 16'h0); #1;
    check("rd_after_wr_lo", mem_rdata, 16'h34AB);
    tick();
    set_req(1'b0, 1'b1, 16'h1006, 2'b10, 16'hCD99); #1;
    check("wr_hi_resp", mem_resp, 1);
    tick();
    set_req(1'b0, 1'b1, 16'h1004, 2'b00, 16'hFFFF); #1;
    check("wr_be0_resp", mem_resp, 1);
    tick();
    set_req(1'b1, 1'b0, 16'h1004, 2'b00, 16'h0); #1;
    check("rd_after_be0", mem_rdata, 16'h2222);
    tick();
    mem_addr = 16'h1006; #1;
    check("rd_after_wr_hi", mem_rdata, 16'hCD33);
    tick();

    // Conflict miss on a dirty line: writeback, then fill
    mem_addr = 16'h1080; #1;
    check("conf_no_resp", mem_resp, 0);
    tick(); #1;
    check("wb_pmem_write", pmem_write, 1);
    check("wb_pmem_read", pmem_read, 0);
    check("wb_pmem_addr", pmem_addr, 16'h1000);
    check("wb_pmem_wdata", pmem_wdata, LINE_A_MOD);
    check("wb_no_resp", mem_resp, 0);
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; #1;
    check("conf_fill_read", pmem_read, 1);
    check("conf_fill_write", pmem_write, 0);
    check("conf_fill_addr", pmem_addr, 16'h1080);
    check("conf_fill_no_resp", mem_resp, 0);
    pmem_rdata = LINE_B; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; #1;
    check("conf_done_resp", mem_resp, 1);
    check("conf_done_rdata", mem_rdata, 16'hA0A0);
    tick();

    // Reset while allocating
    mem_addr = 16'h1000;
    tick(); #1;
    check("pre_rst_pmem_read", pmem_read, 1);
    rst_n = 1'b0; #1;
    check("midrst_pmem_read", pmem_read, 0);
    check("midrst_pmem_addr", pmem_addr, 0);
    check("midrst_resp", mem_resp, 0);
    tick();
    rst_n = 1'b1;
    mem_addr = 16'h1080; #1;
    check("postrst_miss", mem_resp, 0);
    tick(); #1;
    check("postrst_no_wb", pmem_write, 0);
    check("postrst_fill", pmem_read, 1);
    check("postrst_fill_addr", pmem_addr, 16'h1080);
    pmem_rdata = LINE_B; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; #1;
    check("postrst_resp", mem_resp, 1);
    check("postrst_rdata", mem_rdata, 16'hA0A0);
    tick();

    // Read and write together: write wins
    set_req(1'b1, 1'b1, 16'h1082, 2'b11, 16'h5A5A); #1;
    check("rw_resp", mem_resp, 1);
    tick();
    set_req(1'b0, 1'b0, 16'h1082, 2'b00, 16'h0); #1;
    check("rw_single_resp", mem_resp, 0);
    mem_read = 1'b1; #1;
    check("rw_rdata", mem_rdata, 16'h5A5A);
    tick();
    mem_addr = 16'h1000; #1;
    check("rw_conf_no_resp", mem_resp, 0);
    tick(); #1;
    check("rw_wb_write", pmem_write, 1);
    check("rw_wb_addr", pmem_addr, 16'h1080);
    check("rw_wb_wdata", pmem_wdata, LINE_B_MOD);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Responder end of the pipeline's data-memory interface.
- Accepts word/byte read and write requests from the MEM stage: mem_read, mem_write, mem_byte_enable, mem_addr, mem_wdata. Returns mem_rdata and a one-cycle mem_resp.
- Direct-mapped, write-back, write-allocate cache of 16-byte lines.
- Backed by a line-wide physical-memory port with its own read/write/resp handshake.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2); index width = log2(NUM_LINES).
- OFFSET_BITS, 4, byte offset within a line (16-byte line, 128 bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  read request; held until mem_resp.
- mem_write  in  1  write request; held until mem_resp.
- mem_byte_enable  in  2  lc3b_mem_wmask; bit0 = low byte, bit1 = high byte (writes only).
- mem_addr  in  16  byte address; bit0 is ignored for word selection.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  word at mem_addr[3:1]; valid when mem_resp=1 on a read.
- mem_resp  out  1  single-cycle completion pulse.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_addr  out  16  line-aligned address; bits [3:0] = 0.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill data; valid when pmem_resp=1.
- pmem_resp  in  1  physical memory completion pulse.

Behaviour:
- Address split: tag = [15:4+IDX], index = [3+IDX:4], word = [3:1]. With defaults, tag is 9 bits.
- Per-line storage: valid bit, dirty bit, tag, 128-bit data.
- Reset (rst_n=0, asynchronous): all valid/dirty bits cleared, FSM to IDLE, all outputs 0. Data and tag arrays are not reset.
- Reset mid-operation: any pmem request is dropped immediately, and no mem_resp is issued.

FSM states IDLE, WRITEBACK, ALLOCATE:
- IDLE, no request: all outputs 0.
- IDLE, request with hit (valid && tag match): mem_resp=1 combinationally in the same cycle.
  - Read: mem_rdata = selected word.
  - Write: enabled bytes are merged into the line at the clock edge and dirty is set.
  - Remain in IDLE.
- IDLE, request with miss:
  - Victim dirty -> WRITEBACK.
  - Otherwise -> ALLOCATE.
  - mem_resp=0.
- WRITEBACK: pmem_write=1, pmem_addr={victim tag, index, 4'b0}, pmem_wdata = victim line. On pmem_resp: clear dirty, go to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr={req tag, index, 4'b0}.
  - On pmem_resp: write pmem_rdata into the line, set tag, valid=1, dirty=0, return to IDLE.
  - The request then hits on the next cycle.

Latency and handshake rules:
- Latency: hit = 0 extra cycles. Clean miss = fill latency + 1. Dirty miss = writeback + fill + 1.
- mem_resp never asserts outside IDLE.
- pmem_read and pmem_write are never both 1.
- mem_read and mem_write both asserted: mem_write wins, and the read is not serviced.
- mem_byte_enable=2'b00 on a write: responds, but the line and dirty bit are unchanged.
- Requests may change only after mem_resp. Behaviour is undefined if the request changes while the FSM is in WRITEBACK or ALLOCATE.

Decomposition:
- Add to lc3b_types:
  - lc3b_c_tag, lc3b_c_index, lc3b_c_offset, lc3b_c_line (128-bit).
  - Cache FSM state enum.
- Natural split: cache_control (FSM) plus a datapath. The datapath instantiates a parameterized cache_array sub-module, used once each for data, tag, valid and dirty.
- The array has async-reset capability for valid/dirty only.

Test Plan:
- Reset, then read 0x1000 -> pmem_read=1 with pmem_addr=0x1000. Drive pmem_rdata with word0=0xBEEF and pmem_resp -> next cycle mem_resp=1, mem_rdata=0xBEEF.
- Second read of 0x1000 with no intervening traffic -> mem_resp in the same cycle, pmem_read stays 0.
- Write 0x1002, be=2'b01, wdata=0x12AB to a line whose word1 holds 0x3456 -> word1 becomes 0x34AB, and a subsequent read of 0x1002 returns 0x34AB.
- Conflict read of 0x1080 (same index 0, different tag) after the dirty write -> pmem_write with pmem_addr=0x1000 and the modified line first, then pmem_read 0x1080. mem_resp comes only after both pmem_resp pulses.
- Assert rst_n=0 while in ALLOCATE -> pmem_read drops asynchronously, no mem_resp. A re-read of 0x1000 misses because valid was cleared.
- mem_read and mem_write asserted together to a hit line -> write performed, mem_resp=1 once.
